crc_codeword_tx: RTL and testbench

CRC_CODEWORD_TX -- requirements
Module: crc_codeword_tx

---
 rtl/crc_pkg.sv | 21 ++
 rtl/crc_shift_lane.sv | 29 ++
 rtl/crc_codeword_tx.sv | 123 ++++++++++++
 tb/tb_crc_codeword_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the codeword serializer and the parallel CRC stage.
package crc_pkg;

  localparam int unsigned LANES_DEFAULT = 3;
  localparam int unsigned MSG_W_DEFAULT = 9;
  localparam int unsigned CRC_W_DEFAULT = 9;

  // Generator polynomial used by the upstream parallel CRC stage (implicit top bit dropped).
  localparam logic [CRC_W_DEFAULT-1:0] CRC_POLY = 9'h11D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    CRC  = 2'd2
  } crc_state_e;

  function automatic int unsigned beats_of(input int unsigned width, input int unsigned lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/crc_shift_lane.sv
// Loadable left-shifting register emitting its top LANES bits as the current beat.
module crc_shift_lane #(
  parameter int unsigned W     = 18,
  parameter int unsigned LANES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [W-1:0]     load_data,
  output logic [LANES-1:0] tap
);

  logic [W-1:0] sr;

  // Load wins over shift; zeros fill from the right so the register drains to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift_en) begin
      sr <= {sr[W-LANES-1:0], {LANES{1'b0}}};
    end
  end

  assign tap = sr[W-1 -: LANES];

endmodule

// File: rtl/crc_codeword_tx.sv
// Serializes a {message, CRC} pair into LANES-bit beats with valid/ready handshakes.
// Define CRC_INV_EN to transmit the bitwise inverse of the CRC field.
module crc_codeword_tx
  import crc_pkg::*;
#(
  parameter int unsigned MSG_W = MSG_W_DEFAULT,
  parameter int unsigned CRC_W = CRC_W_DEFAULT,
  parameter int unsigned LANES = LANES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] msg_in,
  input  logic [CRC_W-1:0] crc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [7:0]       frame_count
);

  localparam int unsigned MSG_BEATS   = beats_of(MSG_W, LANES);
  localparam int unsigned CRC_BEATS   = beats_of(CRC_W, LANES);
  localparam int unsigned TOTAL_BEATS = MSG_BEATS + CRC_BEATS;
  localparam int unsigned CNT_W       = $clog2(TOTAL_BEATS + 1);
  localparam int unsigned SR_W        = MSG_W + CRC_W;

  crc_state_e       state;
  crc_state_e       next_state;
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             load;
  logic             shift_en;
  logic             frame_done;
  logic [CRC_W-1:0] crc_tx;

`ifdef CRC_INV_EN
  assign crc_tx = ~crc_in;
`else
  assign crc_tx = crc_in;
`endif

  crc_shift_lane #(
    .W     (SR_W),
    .LANES (LANES)
  ) u_lane (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .shift_en  (shift_en),
    .load_data ({msg_in, crc_tx}),
    .tap       (out_data)
  );

  // Next-state, beat counter and shift/load control.
  always_comb begin
    next_state = state;
    next_cnt   = beat_cnt;
    load       = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load       = 1'b1;
          next_state = MSG;
          next_cnt   = '0;
        end
      end
      MSG: begin
        if (out_ready) begin
          shift_en = 1'b1;
          next_cnt = beat_cnt + CNT_W'(1);
          if (next_cnt == CNT_W'(MSG_BEATS)) begin
            next_state = CRC;
          end
        end
      end
      CRC: begin
        if (out_ready) begin
          shift_en = 1'b1;
          if (beat_cnt == CNT_W'(TOTAL_BEATS - 1)) begin
            next_state = IDLE;
            next_cnt   = '0;
            frame_done = 1'b1;
          end else begin
            next_cnt = beat_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      out_last    <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      state     <= next_state;
      beat_cnt  <= next_cnt;
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state != IDLE);
      busy      <= (next_state != IDLE);
      out_last  <= (next_state == CRC) && (next_cnt == CNT_W'(TOTAL_BEATS - 1));
      if (frame_done) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_crc_codeword_tx.sv
// Self-checking bench for crc_codeword_tx: queue-based beat model plus directed literal checks.
module tb_crc_codeword_tx;

  localparam int unsigned MSG_W = 9;
  localparam int unsigned CRC_W = 9;
  localparam int unsigned LANES = 3;
  localparam int unsigned W     = MSG_W + CRC_W;
  localparam int unsigned NB    = W / LANES;

`ifdef CRC_INV_EN
  localparam logic [2:0] EXP [6] = '{3'b101, 3'b011, 3'b010, 3'b111, 3'b000, 3'b110};
`else
  localparam logic [2:0] EXP [6] = '{3'b101, 3'b011, 3'b010, 3'b000, 3'b111, 3'b001};
`endif
  localparam logic [MSG_W-1:0] BASIC_MSG = 9'b101011010;
  localparam logic [CRC_W-1:0] BASIC_CRC = 9'b000111001;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [MSG_W-1:0] msg_in = '0;
  logic [CRC_W-1:0] crc_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [LANES-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic [7:0]       frame_count;

  int total = 0;
  int bad = 0;

  crc_codeword_tx #(
    .MSG_W (MSG_W),
    .CRC_W (CRC_W),
    .LANES (LANES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .msg_in      (msg_in),
    .crc_in      (crc_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: a queue of beats still owed for the current codeword.
  logic [LANES-1:0] mq[$];
  logic [7:0]       m_fc = 8'd0;
  logic [W-1:0]     m_word;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_fc = 8'd0;
    end else if (mq.size() == 0) begin
      if (in_valid) begin
`ifdef CRC_INV_EN
        m_word = {msg_in, ~crc_in};
`else
        m_word = {msg_in, crc_in};
`endif
        for (int i = 0; i < int'(NB); i++) begin
          mq.push_back(LANES'(m_word >> (int'(W) - int'(LANES) * (i + 1))));
        end
      end
    end else if (out_ready) begin
      void'(mq.pop_front());
      if (mq.size() == 0) m_fc = m_fc + 8'd1;
    end
  end

  // Compare and observation process, away from the active edge.
  logic [LANES-1:0] cap[$];
  int               acc[$];
  int               last_cnt = 0;
  int               ir0 = 0;
  int               cyc = 0;

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(mq.size() == 0));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("busy", 32'(busy), 32'(mq.size() != 0));
    chk("out_last", 32'(out_last), 32'(mq.size() == 1));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    if (out_valid && out_ready) begin
      cap.push_back(out_data);
      if (out_last) last_cnt++;
    end
    if (in_valid && in_ready) acc.push_back(cyc);
    if (!in_ready) ir0++;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [MSG_W-1:0] m, input logic [CRC_W-1:0] c);
    int n;
    int g;
    n = acc.size();
    g = 0;
    msg_in   = m;
    crc_in   = c;
    in_valid = 1'b1;
    do begin
      step();
      g++;
    end while (acc.size() == n && g < 50);
    if (acc.size() == n) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_last(input int target);
    int g;
    g = 0;
    while (last_cnt < target && g < 200) begin
      step();
      g++;
    end
    if (last_cnt < target) chk("last_timeout", 32'(last_cnt), 32'(target));
  endtask

  task automatic check_beats(input string name, input int base);
    chk({name, "_count"}, 32'(cap.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < cap.size()) chk(name, 32'(cap[base + i]), 32'(EXP[i]));
    end
  endtask

  initial begin
    int base;
    int n0;
    int g;
    int lc_reset;
    int target;

    // Reset state.
    repeat (2) step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    reset = 1'b0;
    step();

    // Basic frame.
    out_ready = 1'b1;
    base = cap.size();
    target = last_cnt + 1;
    send(BASIC_MSG, BASIC_CRC);
    wait_last(target);
    check_beats("basic_beat", base);
    chk("basic_fc", 32'(frame_count), 32'd1);

    // Backpressure after beat 2.
    base = cap.size();
    target = last_cnt + 1;
    send(BASIC_MSG, BASIC_CRC);
    g = 0;
    while (cap.size() - base < 2 && g < 50) begin
      step();
      g++;
    end
    out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("bp_hold_data", 32'(out_data), 32'(EXP[2]));
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_last(target);
    check_beats("bp_beat", base);
    chk("bp_fc", 32'(frame_count), 32'd2);

    // Back-to-back with in_valid held high.
    ir0 = 0;
    n0 = acc.size();
    target = last_cnt + 2;
    msg_in = 9'h1A5;
    crc_in = 9'h03C;
    in_valid = 1'b1;
    g = 0;
    while (acc.size() < n0 + 2 && g < 100) begin
      step();
      g++;
      if (acc.size() == n0 + 1) begin
        msg_in = 9'h0F0;
        crc_in = 9'h155;
      end
    end
    in_valid = 1'b0;
    wait_last(target);
    if (acc.size() >= n0 + 2) chk("b2b_period", 32'(acc[n0 + 1] - acc[n0]), 32'd7);
    else chk("b2b_accepts", 32'(acc.size() - n0), 32'd2);
    chk("b2b_in_ready_low", 32'(ir0), 32'd12);
    chk("b2b_fc", 32'(frame_count), 32'd4);

    // Reset mid-frame after beat 4.
    base = cap.size();
    send(BASIC_MSG, BASIC_CRC);
    g = 0;
    while (cap.size() - base < 4 && g < 50) begin
      step();
      g++;
    end
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_fc", 32'(frame_count), 32'd0);
    chk("midrst_out_last", 32'(out_last), 32'd0);
    step();
    step();
    reset = 1'b0;
    lc_reset = last_cnt;
    base = cap.size();
    target = last_cnt + 1;
    send(BASIC_MSG, BASIC_CRC);
    wait_last(target);
    check_beats("post_rst_beat", base);
    chk("post_rst_fc", 32'(frame_count), 32'd1);

    // Randomized traffic up to the 256th frame since reset.
    target = lc_reset + 256;
    g = 0;
    while (last_cnt < target && g < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      msg_in    = MSG_W'($urandom);
      crc_in    = CRC_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      g++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (last_cnt < target) chk("wrap_timeout", 32'(last_cnt), 32'(target));
    chk("wrap_fc", 32'(frame_count), 32'd0);
    chk("wrap_last_count", 32'(last_cnt - lc_reset), 32'd256);
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
